// File: rtl/enc8b10b_pkg.sv
// Shared definitions for the 8b/10b lane encoder.
// Holds the running-disparity constants, the K28.5 comma byte, the 10-bit
// symbol type, the valid-K check and the RD- sub-block code tables.
// Sub-block codes are listed MSB-first as transmitted: 6b = abcdei, 4b = fghj.
package enc8b10b_pkg;

    localparam logic       RD_NEG = 1'b0;
    localparam logic       RD_POS = 1'b1;
    localparam logic [7:0] K28_5  = 8'hBC;

    typedef logic [9:0] sym10_t;

    // K28.y for any y, plus the four K x.7 codes
    function automatic logic is_valid_k(input logic [7:0] b);
        return (b[4:0] == 5'd28) || (b == 8'hF7) || (b == 8'hFB) ||
               (b == 8'hFD) || (b == 8'hFE);
    endfunction

    // 5b/6b data codes as emitted under RD-
    function automatic logic [5:0] enc6_neg(input logic [4:0] x);
        logic [5:0] c;
        case (x)
            5'd0:    c = 6'b100111;
            5'd1:    c = 6'b011101;
            5'd2:    c = 6'b101101;
            5'd3:    c = 6'b110001;
            5'd4:    c = 6'b110101;
            5'd5:    c = 6'b101001;
            5'd6:    c = 6'b011001;
            5'd7:    c = 6'b111000;
            5'd8:    c = 6'b111001;
            5'd9:    c = 6'b100101;
            5'd10:   c = 6'b010101;
            5'd11:   c = 6'b110100;
            5'd12:   c = 6'b001101;
            5'd13:   c = 6'b101100;
            5'd14:   c = 6'b011100;
            5'd15:   c = 6'b010111;
            5'd16:   c = 6'b011011;
            5'd17:   c = 6'b100011;
            5'd18:   c = 6'b010011;
            5'd19:   c = 6'b110010;
            5'd20:   c = 6'b001011;
            5'd21:   c = 6'b101010;
            5'd22:   c = 6'b011010;
            5'd23:   c = 6'b111010;
            5'd24:   c = 6'b110011;
            5'd25:   c = 6'b100110;
            5'd26:   c = 6'b010110;
            5'd27:   c = 6'b110110;
            5'd28:   c = 6'b001110;
            5'd29:   c = 6'b101110;
            5'd30:   c = 6'b011110;
            default: c = 6'b101011;
        endcase
        return c;
    endfunction

    // 3b/4b data codes as emitted under RD- (x.7 is the primary 1110)
    function automatic logic [3:0] enc4_neg(input logic [2:0] y);
        logic [3:0] c;
        case (y)
            3'd0:    c = 4'b1011;
            3'd1:    c = 4'b1001;
            3'd2:    c = 4'b0101;
            3'd3:    c = 4'b1100;
            3'd4:    c = 4'b1101;
            3'd5:    c = 4'b1010;
            3'd6:    c = 4'b0110;
            default: c = 4'b1110;
        endcase
        return c;
    endfunction

    // 3b/4b control codes as emitted when the RD entering the 4b block is RD+.
    // Every control code flips RD in its 6b block, so the RD- form is the
    // bitwise complement of this one, neutral codes included.
    function automatic logic [3:0] k4_pos(input logic [2:0] y);
        logic [3:0] c;
        case (y)
            3'd0:    c = 4'b0100;
            3'd1:    c = 4'b1001;
            3'd2:    c = 4'b0101;
            3'd3:    c = 4'b0011;
            3'd4:    c = 4'b0010;
            3'd5:    c = 4'b1010;
            3'd6:    c = 4'b0110;
            default: c = 4'b1000;
        endcase
        return c;
    endfunction

    // RD after a 6b sub-block; 111000/000111 are neutral but still set RD
    function automatic logic rd_after6(input logic [5:0] s, input logic rd);
        int ones;
        ones = $countones(s);
        if (ones > 3)              return RD_POS;
        else if (ones < 3)         return RD_NEG;
        else if (s == 6'b111000)   return RD_NEG;
        else if (s == 6'b000111)   return RD_POS;
        else                       return rd;
    endfunction

    // RD after a 4b sub-block; 1100/0011 are neutral but still set RD
    function automatic logic rd_after4(input logic [3:0] s, input logic rd);
        int ones;
        ones = $countones(s);
        if (ones > 2)              return RD_POS;
        else if (ones < 2)         return RD_NEG;
        else if (s == 4'b1100)     return RD_NEG;
        else if (s == 4'b0011)     return RD_POS;
        else                       return rd;
    endfunction

endpackage

// File: rtl/enc_8b10b_byte.sv
// Combinational 8b/10b encoder for one byte.
// Ports:
//   data_byte  in   byte to encode, HGFEDCBA
//   k          in   control-symbol request
//   rd_in      in   running disparity entering this byte
//   sym        out  10-bit symbol, [9:4]=abcdei, [3:0]=fghj
//   rd_out     out  running disparity after this symbol
//   k_err      out  k requested for a byte that is not a valid K code
// An invalid K request falls back to the D code of the same byte.
module enc_8b10b_byte
    import enc8b10b_pkg::*;
(
    input  logic [7:0] data_byte,
    input  logic       k,
    input  logic       rd_in,
    output sym10_t     sym,
    output logic       rd_out,
    output logic       k_err
);

    logic [4:0] x;
    logic [2:0] y;
    logic       k_ok;
    logic [5:0] code6;
    logic [5:0] sym6;
    logic       rd_mid;
    logic [3:0] code4;
    logic [3:0] sym4;

    assign x     = data_byte[4:0];
    assign y     = data_byte[7:5];
    assign k_ok  = k & is_valid_k(data_byte);
    assign k_err = k & ~k_ok;

    // K28 is the only control code whose 6b block differs from the D table
    assign code6 = (k_ok && (x == 5'd28)) ? 6'b001111 : enc6_neg(x);
    assign code4 = enc4_neg(y);

    always_comb begin
        sym6 = code6;
        if (rd_in && (($countones(code6) != 3) || (code6 == 6'b111000)))
            sym6 = ~code6;
    end

    assign rd_mid = rd_after6(sym6, rd_in);

    always_comb begin
        sym4 = code4;
        if (k_ok) begin
            sym4 = rd_mid ? k4_pos(y) : ~k4_pos(y);
        end else if (y == 3'd7) begin
            // Alternate x.7 avoids a run of five equal bits across e,i,f,g,h
            if (!rd_mid && (sym6[1:0] == 2'b11))
                sym4 = 4'b0111;
            else if (rd_mid && (sym6[1:0] == 2'b00))
                sym4 = 4'b1000;
            else
                sym4 = rd_mid ? 4'b0001 : 4'b1110;
        end else if (rd_mid && (($countones(code4) != 2) || (code4 == 4'b1100))) begin
            sym4 = ~code4;
        end
    end

    assign sym    = {sym6, sym4};
    assign rd_out = rd_after4(sym4, rd_mid);

endmodule

// File: rtl/enc_8b10b_lanes.sv
// Registered multi-lane 8b/10b encoder between the packet framer and the
// serialiser. Running disparity chains lane 0 -> lane NUM_LANES-1 within a
// beat and persists across beats.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input beat handshake
//   in_data, in_k         NUM_LANES bytes (lane n = [8n+7:8n]) and K requests
//   rd_load, rd_value     force RD (applied before encoding an accepted beat)
//   out_valid/out_ready   output beat handshake, one cycle latency
//   out_data, out_k_err   NUM_LANES symbols (lane n = [10n+9:10n]), K errors
//   rd_cur                RD after the last accepted beat
//   err_cnt, err_clr      saturating count of erroring beats, sync clear
module enc_8b10b_lanes
    import enc8b10b_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*NUM_LANES-1:0]  in_data,
    input  logic [NUM_LANES-1:0]    in_k,
    input  logic                    rd_load,
    input  logic                    rd_value,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [10*NUM_LANES-1:0] out_data,
    output logic [NUM_LANES-1:0]    out_k_err,
    output logic                    rd_cur,
    output logic [ERR_CNT_W-1:0]    err_cnt,
    input  logic                    err_clr
);

    logic                    out_valid_reg;
    logic [10*NUM_LANES-1:0] out_data_reg;
    logic [NUM_LANES-1:0]    out_k_err_reg;
    logic                    rd_reg;
    logic [ERR_CNT_W-1:0]    err_cnt_reg;

    logic [NUM_LANES:0]      rd_chain;
    logic [10*NUM_LANES-1:0] enc_data;
    logic [NUM_LANES-1:0]    enc_k_err;
    logic                    accept;

    assign in_ready = ~out_valid_reg | out_ready;
    assign accept   = in_valid & in_ready;

    // rd_load overrides the stored RD for the beat being encoded this cycle
    assign rd_chain[0] = rd_load ? rd_value : rd_reg;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            enc_8b10b_byte u_byte (
                .data_byte (in_data[8*gi +: 8]),
                .k         (in_k[gi]),
                .rd_in     (rd_chain[gi]),
                .sym       (enc_data[10*gi +: 10]),
                .rd_out    (rd_chain[gi+1]),
                .k_err     (enc_k_err[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_k_err_reg <= '0;
            rd_reg        <= RD_NEG;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= enc_data;
            out_k_err_reg <= enc_k_err;
            rd_reg        <= rd_chain[NUM_LANES];
        end else begin
            if (out_ready)
                out_valid_reg <= 1'b0;
            if (rd_load)
                rd_reg <= rd_value;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt_reg <= '0;
        else if (err_clr)
            err_cnt_reg <= '0;
        else if (accept && (|enc_k_err) && !(&err_cnt_reg))
            err_cnt_reg <= err_cnt_reg + ERR_CNT_W'(1);
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_k_err = out_k_err_reg;
    assign rd_cur    = rd_reg;
    assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_enc_8b10b_lanes.sv
module tb_enc_8b10b_lanes;
    import enc8b10b_pkg::*;

    localparam int NL = 2;
    localparam int EW = 2;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [8*NL-1:0]  in_data;
    logic [NL-1:0]    in_k;
    logic           rd_load;
    logic           rd_value;
    logic           out_valid;
    logic           out_ready;
    logic [10*NL-1:0] out_data;
    logic [NL-1:0]    out_k_err;
    logic           rd_cur;
    logic [EW-1:0]    err_cnt;
    logic           err_clr;

    typedef struct packed {
        logic [19:0] data;
        logic [1:0]  kerr;
        logic        rd;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   n_sent   = 0;
    int   n_recv   = 0;

    enc_8b10b_lanes #(.NUM_LANES(NL), .ERR_CNT_W(EW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_k      (in_k),
        .rd_load   (rd_load),
        .rd_value  (rd_value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_k_err (out_k_err),
        .rd_cur    (rd_cur),
        .err_cnt   (err_cnt),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per output transfer
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                n_recv++;
                check("out_data", {12'd0, out_data}, {12'd0, e.data});
                check("out_k_err", {30'd0, out_k_err}, {30'd0, e.kerr});
                check("rd_cur", {31'd0, rd_cur}, {31'd0, e.rd});
                $display("beat %0d: data=%05h k_err=%b rd=%b", n_recv, out_data, out_k_err, rd_cur);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [15:0] d, input logic [1:0] k, input logic rdl,
                        input logic rdv, input logic clr, input logic [19:0] ed,
                        input logic [1:0] ek, input logic er);
        exp_t e;
        int   waited;
        e.data = ed;
        e.kerr = ek;
        e.rd   = er;
        in_data  = d;
        in_k     = k;
        rd_load  = rdl;
        rd_value = rdv;
        err_clr  = clr;
        in_valid = 1'b1;
        exp_q.push_back(e);
        n_sent++;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rd_load  = 1'b0;
        err_clr  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e9;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_k = '0;
        rd_load = 1'b0;
        rd_value = 1'b0;
        out_ready = 1'b1;
        err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {12'd0, out_data}, 32'd0);
        check("rst_out_k_err", {30'd0, out_k_err}, 32'd0);
        check("rst_rd_cur", {31'd0, rd_cur}, 32'd0);
        check("rst_err_cnt", {30'd0, err_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);

        // K28.5,K28.5 and one-cycle latency
        send(16'hBCBC, 2'b11, 0, 0, 0, {10'h305, 10'h0FA}, 2'b00, 1'b0);
        @(negedge clk);
        check("latency_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;

        // D0.0,D21.5 from RD-, then same beat with RD forced to RD+
        send(16'hB500, 2'b00, 0, 0, 0, {10'h2AA, 10'h274}, 2'b00, 1'b0);
        send(16'hB500, 2'b00, 1, 1, 0, {10'h2AA, 10'h18B}, 2'b00, 1'b1);
        // A7 selection: D17.7 under RD-, then D0.7 under RD-
        send(16'hB5F1, 2'b00, 1, 0, 0, {10'h2AA, 10'h237}, 2'b00, 1'b1);
        send(16'hB5E0, 2'b00, 1, 0, 0, {10'h2AA, 10'h271}, 2'b00, 1'b0);
        // Invalid K on lane 0
        send(16'hB500, 2'b01, 0, 0, 0, {10'h2AA, 10'h274}, 2'b01, 1'b0);
        check("err_cnt_one", {30'd0, err_cnt}, 32'd1);
        // err_clr beats a simultaneous increment
        send(16'h00B5, 2'b10, 0, 0, 1, {10'h274, 10'h2AA}, 2'b10, 1'b0);
        check("err_cnt_clr", {30'd0, err_cnt}, 32'd0);
        // K23.7 and K28.0
        send(16'h1CF7, 2'b11, 0, 0, 0, {10'h0F4, 10'h3A8}, 2'b00, 1'b0);
        @(posedge clk); #1;

        // Backpressure: beat 9 held for three cycles, beat 10 waits
        out_ready = 1'b0;
        e9.data = {10'h18B, 10'h31B};
        e9.kerr = 2'b00;
        e9.rd   = 1'b1;
        in_data = 16'h0003;
        in_k = 2'b00;
        in_valid = 1'b1;
        exp_q.push_back(e9);
        n_sent++;
        @(posedge clk); #1;
        begin
            exp_t e10;
            e10.data = {10'h38C, 10'h071};
            e10.kerr = 2'b00;
            e10.rd   = 1'b0;
            in_data = 16'h67E7;
            exp_q.push_back(e10);
            n_sent++;
        end
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_out_data", {12'd0, out_data}, {12'd0, e9.data});
            check("bp_rd_cur", {31'd0, rd_cur}, 32'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;

        // D11.7 alternate under RD+, then K28.7
        send(16'hFCEB, 2'b10, 1, 1, 0, {10'h0F8, 10'h348}, 2'b00, 1'b0);
        check("err_cnt_zero", {30'd0, err_cnt}, 32'd0);

        // Saturation of the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            send(16'h0000, 2'b01, 0, 0, 0, {10'h274, 10'h274}, 2'b01, 1'b0);
            if (i == 2) check("err_cnt_three", {30'd0, err_cnt}, 32'd3);
        end
        check("err_cnt_sat", {30'd0, err_cnt}, 32'd3);

        // rd_load without an accept
        rd_load = 1'b1;
        rd_value = 1'b1;
        @(posedge clk); #1;
        rd_load = 1'b0;
        check("rd_load_idle", {31'd0, rd_cur}, 32'd1);

        // Pending beat discarded by reset mid-stream
        out_ready = 1'b0;
        in_data = 16'h0000;
        in_k = 2'b00;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        check("pre_rst_data", {12'd0, out_data}, {12'd0, 10'h18B, 10'h18B});
        check("pre_rst_rd", {31'd0, rd_cur}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_rd", {31'd0, rd_cur}, 32'd0);
        check("mid_rst_err_cnt", {30'd0, err_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // RD- restored after reset
        send(16'hB5B5, 2'b00, 0, 0, 0, {10'h2AA, 10'h2AA}, 2'b00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);
        check("beats_out", n_recv, n_sent);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/enc_8b10b_lanes.md
Name: enc_8b10b_lanes

Overview:
- Parametrised, registered 8b/10b encoder, the successor to our combinational 3b/4b sub-block encoder in the IEEE1149.10 link transmit path.
- Each beat carries NUM_LANES bytes. Running disparity (RD) is tracked internally and chained lane 0 -> lane NUM_LANES-1 within a beat. RD persists across beats.
- The D.x.7 alternate-encoding selection (A7) is computed internally, so no external d_select/k_select inputs are needed.
- Valid/ready handshake on both sides, a 1-cycle registered output, and a saturating K-error counter. Sits between the packet framer and the serialiser.

Parameters:
- NUM_LANES, 2, bytes encoded per beat (1..8).
- ERR_CNT_W, 8, width of the saturating K-error counter.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous assert, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_data  in  8*NUM_LANES  lane n = bits [8n+7:8n], HGFEDCBA.
- in_k  in  NUM_LANES  per-lane control-symbol request.
- rd_load  in  1  force RD to rd_value (training/resync).
- rd_value  in  1  RD to load; 0 = RD-, 1 = RD+.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- out_data  out  10*NUM_LANES  lane n = bits [10n+9:10n]; within a lane, [9:4]=abcdei, [3:0]=fghj; bit 9 is transmitted first.
- out_k_err  out  NUM_LANES  lane requested an invalid K code.
- rd_cur  out  1  running disparity after the last accepted beat.
- err_cnt  out  ERR_CNT_W  count of accepted beats with any k_err.
- err_clr  in  1  synchronous clear of err_cnt.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_k_err=0, rd_cur=0 (RD-), err_cnt=0. in_ready is 1 when rst_n is high.
- Acceptance: a beat is accepted when in_valid & in_ready, with in_ready = !out_valid | out_ready.
  - Accepted beat: registered into out_* the next cycle, so latency is 1.
  - out_valid clears on out_ready when no new beat is accepted.
  - out_data and out_k_err hold stable while out_valid & !out_ready.
- Per-lane encoding (combinational, standard IBM 8b/10b):
  - Input RD for lane 0 = rd_cur; input RD for lane n = ending RD of lane n-1.
  - 5b/6b: RD- selects the encoding with more ones (or neutral); RD+ selects its complement.
  - D.7: 111000 under RD-, 000111 under RD+.
  - 3b/4b: same disparity rule. D.x.3 is 1100 under RD- and 0011 under RD+.
  - D.x.7 uses 1110/0001, except 0111 when RD- and e=i=1, and 1000 when RD+ and e=i=0.
- Sub-block RD update: a non-neutral sub-block sets RD to its sign. 000111 and 0011 end RD+; 111000 and 1100 end RD-. Any other neutral sub-block leaves RD unchanged.
- Valid K codes: K28.0-K28.7, K23.7, K27.7, K29.7, K30.7.
  - For any other byte with in_k=1: out_k_err[n]=1 and the lane is encoded as the D code of the same byte. RD follows the emitted code.
- rd_cur update on accept: the ending RD of the last lane.
- rd_load:
  - rd_load with no accept: rd_cur <= rd_value.
  - rd_load in the same cycle as an accept: the beat is encoded starting from rd_value, and rd_cur <= that beat's ending RD.
- err_cnt:
  - +1 per accepted beat with any out_k_err bit set; saturates at all-ones.
  - err_clr has priority over increment, giving 0 that cycle.
- Reset mid-operation: the pending output beat is discarded and RD returns to RD-.

Decomposition:
- enc8b10b_pkg holds:
  - RD_NEG/RD_POS constants.
  - K28_5 = 8'hBC.
  - The valid-K list as a function is_valid_k(byte).
  - 6b/4b code tables as functions.
  - A typedef for the 10-bit symbol.
- Sub-module enc_8b10b_byte: combinational; inputs byte, k, rd_in; outputs sym[9:0], rd_out, k_err. Instantiated NUM_LANES times in a generate loop; the top level holds the registers and handshake.

Test Plan:
- Reset, then one beat of K28.5,K28.5 (NUM_LANES=2, in_k=2'b11) -> lane0=10'h0FA, lane1=10'h305, rd_cur=0, latency 1 cycle.
- Beat D0.0,D21.5 from RD- -> lane0=10'h274, lane1=10'h2AA, rd_cur=0; with rd_load=1, rd_value=1 on the same cycle -> lane0=10'h18B (011000 1011), lane1=10'h2AA, rd_cur=1.
- A7 check: D17.7 (8'hF1) with rd_cur=0 -> 10'h237 (100011 0111); D0.7 (8'hE0) with rd_cur=0 -> 10'h271 (100111 0001).
- Invalid K: in_k=01, byte 8'h00 -> out_k_err=01, lane0=10'h274, err_cnt=1. Then err_clr together with another erroring beat -> err_cnt=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid high -> in_ready=0, out_data stable, rd_cur unchanged; on release each beat is output exactly once, in order.
- Saturation with ERR_CNT_W=2: 5 erroring beats -> err_cnt=3. Then rst_n pulse mid-stream -> out_valid=0 and rd_cur=0 immediately.
